// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, constants and the operand forwarding select
// used by the write-back bookkeeping pipeline.
package hazard_pkg;

  localparam int DEF_AW = 5;
  localparam int DEF_TW = 2;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  typedef struct packed {
    logic              regW;
    logic [DEF_AW-1:0] regWa;
    logic [DEF_TW-1:0] Tnew;
  } stage_t;

  localparam stage_t BUBBLE = '{regW: 1'b0, regWa: '0, Tnew: '0};

  // Nearest writer wins; a nearest writer that is not ready yet
  // hides older ones and yields FWD_RF (the stall covers it).
  function automatic logic [1:0] fwd_sel(
    input logic [DEF_AW-1:0] src,
    input logic              use_e,
    input stage_t            e,
    input stage_t            m,
    input stage_t            w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (src == '0) begin
      sel = FWD_RF;
    end else if (use_e && e.regW && e.regWa == src) begin
      sel = (e.Tnew == '0) ? FWD_E : FWD_RF;
    end else if (m.regW && m.regWa == src) begin
      sel = (m.Tnew == '0) ? FWD_M : FWD_RF;
    end else if (w.regW && w.regWa == src) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_stage.sv
// hazard_stage: one pipeline slice of write-back info with bubble insert,
// $0 normalisation and saturating Tnew decrement; optional rs/rt carry.
// Ports: clk, reset (async low), bubble, dec, in_* -> out_* registered.
module hazard_stage
  import hazard_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int TW      = DEF_TW,
  parameter bit HAS_SRC = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bubble,
  input  logic          dec,
  input  logic          in_regW,
  input  logic [AW-1:0] in_regWa,
  input  logic [TW-1:0] in_tnew,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  output logic          out_regW,
  output logic [AW-1:0] out_regWa,
  output logic [TW-1:0] out_tnew,
  output logic [AW-1:0] out_rs,
  output logic [AW-1:0] out_rt
);

  logic          regW_d, regW_q;
  logic [AW-1:0] regWa_d, regWa_q;
  logic [TW-1:0] tnew_d, tnew_q;

  always_comb begin
    regW_d  = in_regW && (in_regWa != '0);
    regWa_d = regW_d ? in_regWa : '0;
    tnew_d  = '0;
    if (regW_d) begin
      tnew_d = (dec && in_tnew != '0) ? in_tnew - TW'(1) : in_tnew;
    end
    if (bubble) begin
      regW_d  = 1'b0;
      regWa_d = '0;
      tnew_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regW_q  <= 1'b0;
      regWa_q <= '0;
      tnew_q  <= '0;
    end else begin
      regW_q  <= regW_d;
      regWa_q <= regWa_d;
      tnew_q  <= tnew_d;
    end
  end

  assign out_regW  = regW_q;
  assign out_regWa = regWa_q;
  assign out_tnew  = tnew_q;

  if (HAS_SRC) begin : g_src
    logic [AW-1:0] rs_d, rs_q, rt_d, rt_q;

    always_comb begin
      rs_d = bubble ? '0 : in_rs;
      rt_d = bubble ? '0 : in_rt;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rs_q <= '0;
        rt_q <= '0;
      end else begin
        rs_q <= rs_d;
        rt_q <= rt_d;
      end
    end

    assign out_rs = rs_q;
    assign out_rt = rt_q;
  end else begin : g_nosrc
    logic src_unused;
    assign src_unused = ^{in_rs, in_rt};
    assign out_rs = '0;
    assign out_rt = '0;
  end

endmodule

// File: rtl/hazard_pipe.sv
// hazard_pipe: carries write-back info D->E->M->W, bubbles E on isStall,
// and produces D/E-stage operand forwarding selects.
// Ports: clk, reset (async low), isStall, D_* in; E_/M_/W_* and *_fwd_* out.
module hazard_pipe
  import hazard_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int TW = DEF_TW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          isStall,
  input  logic [AW-1:0] D_rs,
  input  logic [AW-1:0] D_rt,
  input  logic          D_regW,
  input  logic [AW-1:0] D_regWa,
  input  logic [TW-1:0] D_Tnew,
  output logic          E_regW,
  output logic          M_regW,
  output logic          W_regW,
  output logic [AW-1:0] E_regWa,
  output logic [AW-1:0] M_regWa,
  output logic [AW-1:0] W_regWa,
  output logic [TW-1:0] E_Tnew,
  output logic [TW-1:0] M_Tnew,
  output logic [AW-1:0] E_rs,
  output logic [AW-1:0] E_rt,
  output logic [1:0]    D_fwd_rs,
  output logic [1:0]    D_fwd_rt,
  output logic [1:0]    E_fwd_rs,
  output logic [1:0]    E_fwd_rt
);

  logic [AW-1:0] m_rs_unused, m_rt_unused;
  logic [AW-1:0] w_rs_unused, w_rt_unused;
  logic [TW-1:0] w_tnew_unused;

  hazard_stage #(.AW(AW), .TW(TW), .HAS_SRC(1'b1)) u_e (
    .clk      (clk),
    .reset    (reset),
    .bubble   (isStall),
    .dec      (1'b0),
    .in_regW  (D_regW),
    .in_regWa (D_regWa),
    .in_tnew  (D_Tnew),
    .in_rs    (D_rs),
    .in_rt    (D_rt),
    .out_regW (E_regW),
    .out_regWa(E_regWa),
    .out_tnew (E_Tnew),
    .out_rs   (E_rs),
    .out_rt   (E_rt)
  );

  hazard_stage #(.AW(AW), .TW(TW), .HAS_SRC(1'b0)) u_m (
    .clk      (clk),
    .reset    (reset),
    .bubble   (1'b0),
    .dec      (1'b1),
    .in_regW  (E_regW),
    .in_regWa (E_regWa),
    .in_tnew  (E_Tnew),
    .in_rs    ({AW{1'b0}}),
    .in_rt    ({AW{1'b0}}),
    .out_regW (M_regW),
    .out_regWa(M_regWa),
    .out_tnew (M_Tnew),
    .out_rs   (m_rs_unused),
    .out_rt   (m_rt_unused)
  );

  // W has no latency left, so its Tnew is fed and held at zero.
  hazard_stage #(.AW(AW), .TW(TW), .HAS_SRC(1'b0)) u_w (
    .clk      (clk),
    .reset    (reset),
    .bubble   (1'b0),
    .dec      (1'b0),
    .in_regW  (M_regW),
    .in_regWa (M_regWa),
    .in_tnew  ({TW{1'b0}}),
    .in_rs    ({AW{1'b0}}),
    .in_rt    ({AW{1'b0}}),
    .out_regW (W_regW),
    .out_regWa(W_regWa),
    .out_tnew (w_tnew_unused),
    .out_rs   (w_rs_unused),
    .out_rt   (w_rt_unused)
  );

  stage_t e_s, m_s, w_s;

  always_comb begin
    e_s       = BUBBLE;
    m_s       = BUBBLE;
    w_s       = BUBBLE;
    e_s.regW  = E_regW;
    e_s.regWa = DEF_AW'(E_regWa);
    e_s.Tnew  = DEF_TW'(E_Tnew);
    m_s.regW  = M_regW;
    m_s.regWa = DEF_AW'(M_regWa);
    m_s.Tnew  = DEF_TW'(M_Tnew);
    w_s.regW  = W_regW;
    w_s.regWa = DEF_AW'(W_regWa);
  end

  always_comb begin
    D_fwd_rs = fwd_sel(DEF_AW'(D_rs), 1'b1, e_s, m_s, w_s);
    D_fwd_rt = fwd_sel(DEF_AW'(D_rt), 1'b1, e_s, m_s, w_s);
    E_fwd_rs = fwd_sel(DEF_AW'(E_rs), 1'b0, e_s, m_s, w_s);
    E_fwd_rt = fwd_sel(DEF_AW'(E_rt), 1'b0, e_s, m_s, w_s);
  end

endmodule

// File: tb/tb_hazard_pipe.sv
// tb_hazard_pipe: randomized bench for hazard_pipe against an
// issue-history reference model, plus directed latency/reset cases.
module tb_hazard_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       isStall;
  logic [4:0] D_rs, D_rt, D_regWa;
  logic       D_regW;
  logic [1:0] D_Tnew;
  logic       E_regW, M_regW, W_regW;
  logic [4:0] E_regWa, M_regWa, W_regWa;
  logic [1:0] E_Tnew, M_Tnew;
  logic [4:0] E_rs, E_rt;
  logic [1:0] D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt;

  always #5 clk = ~clk;

  hazard_pipe #(.AW(5), .TW(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .isStall (isStall),
    .D_rs    (D_rs),
    .D_rt    (D_rt),
    .D_regW  (D_regW),
    .D_regWa (D_regWa),
    .D_Tnew  (D_Tnew),
    .E_regW  (E_regW),
    .M_regW  (M_regW),
    .W_regW  (W_regW),
    .E_regWa (E_regWa),
    .M_regWa (M_regWa),
    .W_regWa (W_regWa),
    .E_Tnew  (E_Tnew),
    .M_Tnew  (M_Tnew),
    .E_rs    (E_rs),
    .E_rt    (E_rt),
    .D_fwd_rs(D_fwd_rs),
    .D_fwd_rt(D_fwd_rt),
    .E_fwd_rs(E_fwd_rs),
    .E_fwd_rt(E_fwd_rt)
  );

  typedef struct {
    bit w;
    int a;
    int t;
    int rs;
    int rt;
  } rec_t;

  // hist[0] is the instruction issued one edge ago (E),
  // hist[1] two edges ago (M), hist[2] three edges ago (W).
  rec_t hist[$];
  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic rec_t bub();
    rec_t r;
    r = '{w: 0, a: 0, t: 0, rs: 0, rt: 0};
    return r;
  endfunction

  task automatic clear_hist();
    hist.delete();
    repeat (3) hist.push_back(bub());
  endtask

  function automatic int age_tnew(int age);
    int t;
    if (age == 0) t = hist[0].t;
    else if (age == 1) t = (hist[1].t > 0) ? hist[1].t - 1 : 0;
    else t = 0;
    return t;
  endfunction

  function automatic int mdl_fwd(int src, bit use_e);
    int first;
    first = use_e ? 0 : 1;
    if (src == 0) return 0;
    for (int age = first; age < 3; age++) begin
      if (hist[age].w && hist[age].a == src)
        return (age_tnew(age) != 0) ? 0 : age + 1;
    end
    return 0;
  endfunction

  task automatic check_all();
    chk("E_regW", E_regW, hist[0].w);
    chk("E_regWa", E_regWa, hist[0].a);
    chk("E_Tnew", E_Tnew, age_tnew(0));
    chk("E_rs", E_rs, hist[0].rs);
    chk("E_rt", E_rt, hist[0].rt);
    chk("M_regW", M_regW, hist[1].w);
    chk("M_regWa", M_regWa, hist[1].a);
    chk("M_Tnew", M_Tnew, age_tnew(1));
    chk("W_regW", W_regW, hist[2].w);
    chk("W_regWa", W_regWa, hist[2].a);
    chk("D_fwd_rs", D_fwd_rs, mdl_fwd(int'(D_rs), 1'b1));
    chk("D_fwd_rt", D_fwd_rt, mdl_fwd(int'(D_rt), 1'b1));
    chk("E_fwd_rs", E_fwd_rs, mdl_fwd(hist[0].rs, 1'b0));
    chk("E_fwd_rt", E_fwd_rt, mdl_fwd(hist[0].rt, 1'b0));
  endtask

  task automatic cyc(input bit st, input bit rw, input int wa,
                     input int tn, input int rs, input int rt);
    rec_t r;
    @(negedge clk);
    isStall = st;
    D_regW  = rw;
    D_regWa = wa[4:0];
    D_Tnew  = tn[1:0];
    D_rs    = rs[4:0];
    D_rt    = rt[4:0];
    #1;
    check_all();
    @(posedge clk);
    if (reset) begin
      r = bub();
      if (!st) begin
        r.w  = rw && (wa != 0);
        r.a  = r.w ? wa : 0;
        r.t  = r.w ? tn : 0;
        r.rs = rs;
        r.rt = rt;
      end
      hist.push_front(r);
      void'(hist.pop_back());
    end
  endtask

  task automatic rnd_cyc();
    cyc($urandom_range(3) == 0, $urandom_range(9) < 7,
        $urandom_range(7), $urandom_range(3),
        $urandom_range(7), $urandom_range(7));
  endtask

  initial begin
    clear_hist();
    reset   = 1'b0;
    isStall = 1'b1;
    D_regW  = 1'b1;
    D_regWa = 5'd3;
    D_Tnew  = 2'd1;
    D_rs    = 5'd0;
    D_rt    = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // Latency D -> E -> M -> W with Tnew decrement
    cyc(0, 1, 8, 1, 0, 0);
    #1;
    chk("p1_E_regWa", E_regWa, 8);
    chk("p1_E_Tnew", E_Tnew, 1);
    cyc(0, 0, 0, 0, 0, 0);
    #1;
    chk("p1_M_regWa", M_regWa, 8);
    chk("p1_M_Tnew", M_Tnew, 0);
    cyc(0, 0, 0, 0, 0, 0);
    #1;
    chk("p1_W_regWa", W_regWa, 8);

    // $10 in E and M, both ready: nearest (E) wins
    cyc(0, 1, 10, 1, 0, 0);
    cyc(0, 1, 10, 0, 0, 0);
    #1;
    D_rt = 5'd10;
    #1;
    chk("p3_nearest", D_fwd_rt, 1);

    // Write to $0 is not a write
    cyc(0, 1, 0, 2, 0, 0);
    #1;
    chk("p4_E_regW", E_regW, 0);
    chk("p4_E_regWa", E_regWa, 0);
    chk("p4_E_Tnew", E_Tnew, 0);

    // Load to $9 followed by two stalls with a $9 consumer in D
    cyc(0, 1, 9, 2, 0, 0);
    cyc(1, 0, 0, 0, 9, 0);
    cyc(1, 0, 0, 0, 9, 0);
    cyc(0, 0, 0, 0, 9, 0);

    // Tnew = 3 reaches M as 2
    cyc(0, 1, 4, 3, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    #1;
    chk("sat_M_Tnew", M_Tnew, 2);

    for (int i = 0; i < 300; i++) rnd_cyc();

    // Pipeline full of writes, then asynchronous reset between edges
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 2, 0, 0, 0);
    cyc(0, 1, 3, 0, 1, 2);
    #2;
    reset = 1'b0;
    clear_hist();
    #1;
    chk("rst_E_regW", E_regW, 0);
    chk("rst_M_regW", M_regW, 0);
    chk("rst_W_regWa", W_regWa, 0);
    check_all();
    cyc(1, 1, 5, 1, 5, 5);
    @(negedge clk);
    reset = 1'b1;
    cyc(0, 1, 6, 1, 0, 0);
    #1;
    chk("post_rst_E", E_regWa, 6);
    chk("post_rst_M", M_regW, 0);

    for (int i = 0; i < 300; i++) rnd_cyc();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
